// File: rtl/seq_match_monitor.sv
// seq_match_monitor
//   Watches the one-cycle match pulse of the 1101 sequence detector.
//   - Counts matches inside a window of WIN_LEN cycles that starts at the match
//     which opens it.
//   - Raises an alarm once THRESH matches fall inside one window.
//   - Keeps a saturating lifetime match count.
//   - After every alarm, a HOLDOFF period stops a single burst from
//     re-triggering the alarm.
//
//   Build option SEQMON_STICKY_EN:
//     defined   - alarm is sticky and is cleared only by clr or rst.
//     undefined - alarm drops on the edge that leaves HOLDOFF, and is also
//                 cleared by en=0, clr or rst.
//   alarm_pulse behaves the same in both builds.
//
//   Every output is registered. rst is asynchronous and active-high.
//   A valid match is match_in & en & ~clr. Its effect shows one cycle later.

module seq_match_monitor #(
  parameter int WIN_LEN  = 16,
  parameter int THRESH   = 3,
  parameter int HOLD_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          match_in,
  input  logic                          clr,
  output logic                          alarm,
  output logic                          alarm_pulse,
  output logic [$clog2(THRESH+1)-1:0]   win_cnt,
  output logic [CNT_W-1:0]              total_cnt,
  output logic                          busy
);

  localparam int WC_W  = $clog2(THRESH + 1);
  localparam int TMAX  = (WIN_LEN > HOLD_LEN) ? WIN_LEN : HOLD_LEN;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);
  localparam logic [WC_W-1:0]  THRESH_C  = WC_W'(THRESH);
  localparam logic [WC_W-1:0]  THRESH_M1 = WC_W'(THRESH - 1);
  localparam logic [TMR_W-1:0] WIN_LOAD  = TMR_W'(WIN_LEN - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

`ifdef SEQMON_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDOW  = 2'd1,
    ALARM   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             vld_match;

  // Lifetime count: stops at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Alarm value at the points that release it. A sticky alarm keeps its
  // value there; otherwise it is dropped.
  function automatic logic alarm_release(input logic cur);
    return STICKY ? cur : 1'b0;
  endfunction

  // A match counts only while the monitor is enabled and not being cleared.
  assign vld_match = match_in & en & ~clr;

  // Single FSM register block: state, window timer, counters, and the
  // registered flags.
  //
  // The window timer holds the number of window edges still to come,
  // including the current cycle's edge. So the window closes on the edge
  // where timer==1. The hold-off timer counts down to 0 and exits on the
  // edge where it reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      win_cnt     <= '0;
      total_cnt   <= '0;
      alarm       <= 1'b0;
      alarm_pulse <= 1'b0;
      busy        <= 1'b0;
    end else if (clr) begin
      // clr wins over en and over any match in the same cycle.
      state       <= IDLE;
      timer       <= '0;
      win_cnt     <= '0;
      total_cnt   <= '0;
      alarm       <= 1'b0;
      alarm_pulse <= 1'b0;
      busy        <= 1'b0;
    end else if (!en) begin
      // Disabled: drop any open window and hold the lifetime count.
      state       <= IDLE;
      timer       <= '0;
      win_cnt     <= '0;
      alarm_pulse <= 1'b0;
      busy        <= 1'b0;
      alarm       <= alarm_release(alarm);
    end else begin
      alarm_pulse <= 1'b0;

      // Every valid match is counted, whatever the state.
      if (vld_match) begin
        total_cnt <= sat_inc(total_cnt);
      end

      unique case (state)
        IDLE: begin
          if (vld_match) begin
            if (THRESH == 1) begin
              state       <= ALARM;
              win_cnt     <= THRESH_C;
              timer       <= '0;
              alarm       <= 1'b1;
              alarm_pulse <= 1'b1;
              busy        <= 1'b1;
            end else begin
              state   <= WINDOW;
              win_cnt <= WC_ONE;
              timer   <= WIN_LOAD;
              busy    <= 1'b1;
            end
          end
        end

        WINDOW: begin
          if (vld_match && (win_cnt == THRESH_M1)) begin
            // Reaching THRESH wins, even on the edge where the window
            // closes.
            state       <= ALARM;
            win_cnt     <= THRESH_C;
            timer       <= '0;
            alarm       <= 1'b1;
            alarm_pulse <= 1'b1;
            busy        <= 1'b1;
          end else if (timer == TMR_ONE) begin
            state   <= IDLE;
            win_cnt <= '0;
            timer   <= '0;
            busy    <= 1'b0;
          end else begin
            timer <= timer - TMR_ONE;
            if (vld_match) begin
              win_cnt <= win_cnt + WC_ONE;
            end
          end
        end

        ALARM: begin
          state   <= HOLDOFF;
          win_cnt <= '0;
          timer   <= HOLD_LOAD;
          busy    <= 1'b1;
        end

        HOLDOFF: begin
          // The window logic ignores matches here, including one on the
          // exit edge.
          if (timer == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            alarm <= alarm_release(alarm);
          end else begin
            timer <= timer - TMR_ONE;
          end
        end

        default: begin
          state   <= IDLE;
          win_cnt <= '0;
          timer   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_monitor.sv
// Bench for seq_match_monitor with default parameters.
//
// Structure:
//   - The stimulus process drives directed match patterns. For each one it
//     queues the expected output values, keyed by the cycle in which they
//     must hold.
//   - A separate monitor process samples the outputs on every falling edge
//     and retires every entry that is due in that cycle.
//
// Cycle numbering: "cycle N" of a scenario is the cycle whose outputs show
// the effect of inputs driven up to cycle N-1.

module tb_seq_match_monitor;

  localparam int WIN_LEN  = 16;
  localparam int THRESH   = 3;
  localparam int HOLD_LEN = 4;
  localparam int CNT_W    = 8;
  localparam int WC_W     = $clog2(THRESH + 1);

`ifdef SEQMON_STICKY_EN
  localparam int STICKY = 1;
`else
  localparam int STICKY = 0;
`endif

  localparam int S_ALARM = 0;
  localparam int S_PULSE = 1;
  localparam int S_WIN   = 2;
  localparam int S_TOTAL = 3;
  localparam int S_BUSY  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             match_in = 1'b0;
  logic             clr = 1'b0;
  logic             alarm;
  logic             alarm_pulse;
  logic [WC_W-1:0]  win_cnt;
  logic [CNT_W-1:0] total_cnt;
  logic             busy;

  seq_match_monitor #(
    .WIN_LEN (WIN_LEN),
    .THRESH  (THRESH),
    .HOLD_LEN(HOLD_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .match_in   (match_in),
    .clr        (clr),
    .alarm      (alarm),
    .alarm_pulse(alarm_pulse),
    .win_cnt    (win_cnt),
    .total_cnt  (total_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic int observe(input int s);
    case (s)
      S_ALARM: return int'(alarm);
      S_PULSE: return int'(alarm_pulse);
      S_WIN:   return int'(win_cnt);
      S_TOTAL: return int'(total_cnt);
      default: return int'(busy);
    endcase
  endfunction

  task automatic expect_at(input int due, input int s, input int v, input string nm);
    exp_t e;
    e.due  = due;
    e.sig  = s;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic expect_zero(input int due, input string tag);
    expect_at(due, S_ALARM, 0, {tag, ".alarm"});
    expect_at(due, S_PULSE, 0, {tag, ".alarm_pulse"});
    expect_at(due, S_WIN,   0, {tag, ".win_cnt"});
    expect_at(due, S_TOTAL, 0, {tag, ".total_cnt"});
    expect_at(due, S_BUSY,  0, {tag, ".busy"});
  endtask

  // Monitor: retire every expectation that falls due in this cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          checks++;
          if (sb[i].due < cyc) begin
            errors++;
            $display("FAIL %s: never sampled (due cycle %0d, now %0d)",
                     sb[i].name, sb[i].due, cyc);
          end else if (observe(sb[i].sig) != sb[i].val) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     sb[i].name, observe(sb[i].sig), sb[i].val, cyc);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pat(input logic [63:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      match_in = pat[i];
      step();
    end
    match_in = 1'b0;
  endtask

  // One-cycle clr with a simultaneous match; everything must read zero.
  task automatic do_clr(input string tag);
    clr      = 1'b1;
    match_in = 1'b1;
    expect_zero(cyc + 1, tag);
    step();
    clr      = 1'b0;
    match_in = 1'b0;
  endtask

  int          t0;
  logic [63:0] p;

  initial begin
    // ---- 1: reset state, then asynchronous reset in the middle of a window
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_zero(cyc, "rst_state");
    step();
    en = 1'b1;
    t0 = cyc;
    expect_at(t0 + 1, S_WIN,   1, "t1.win_c1");
    expect_at(t0 + 1, S_TOTAL, 1, "t1.total_c1");
    expect_at(t0 + 1, S_BUSY,  1, "t1.busy_c1");
    p = '0;
    p[0] = 1'b1;
    p[1] = 1'b1;
    run_pat(p, 2);
    rst = 1'b1;
    expect_zero(cyc, "t1.async_rst");
    step();
    rst = 1'b0;
    expect_at(cyc,     S_BUSY,  0, "t1.busy_release");
    expect_at(cyc + 1, S_BUSY,  0, "t1.busy_after");
    expect_at(cyc + 1, S_TOTAL, 0, "t1.total_after");
    step();

    // ---- 2: matches at cycles 0, 5 and 10 raise the alarm
    t0 = cyc;
    expect_at(t0 + 1,  S_WIN,   1, "t2.win_c1");
    expect_at(t0 + 1,  S_BUSY,  1, "t2.busy_c1");
    expect_at(t0 + 1,  S_TOTAL, 1, "t2.total_c1");
    expect_at(t0 + 6,  S_WIN,   2, "t2.win_c6");
    expect_at(t0 + 10, S_PULSE, 0, "t2.pulse_c10");
    expect_at(t0 + 11, S_PULSE, 1, "t2.pulse_c11");
    expect_at(t0 + 11, S_ALARM, 1, "t2.alarm_c11");
    expect_at(t0 + 11, S_TOTAL, 3, "t2.total_c11");
    expect_at(t0 + 12, S_PULSE, 0, "t2.pulse_c12");
    expect_at(t0 + 12, S_WIN,   0, "t2.win_c12");
    expect_at(t0 + 12, S_BUSY,  1, "t2.busy_c12");
    expect_at(t0 + 12, S_ALARM, 1, "t2.alarm_c12");
    expect_at(t0 + 15, S_BUSY,  1, "t2.busy_c15");
    expect_at(t0 + 16, S_BUSY,  0, "t2.busy_c16");
    expect_at(t0 + 16, S_ALARM, STICKY, "t2.alarm_c16");
    expect_at(t0 + 16, S_TOTAL, 3, "t2.total_c16");
    p = '0;
    p[0]  = 1'b1;
    p[5]  = 1'b1;
    p[10] = 1'b1;
    run_pat(p, 20);
    do_clr("t2.clr");

    // ---- 3: two matches, then the window expires
    t0 = cyc;
    expect_at(t0 + 11, S_PULSE, 0, "t3.pulse_c11");
    expect_at(t0 + 15, S_WIN,   2, "t3.win_c15");
    expect_at(t0 + 15, S_BUSY,  1, "t3.busy_c15");
    expect_at(t0 + 16, S_WIN,   0, "t3.win_c16");
    expect_at(t0 + 16, S_BUSY,  0, "t3.busy_c16");
    expect_at(t0 + 16, S_ALARM, 0, "t3.alarm_c16");
    expect_at(t0 + 16, S_TOTAL, 2, "t3.total_c16");
    p = '0;
    p[0] = 1'b1;
    p[5] = 1'b1;
    run_pat(p, 20);
    do_clr("t3.clr");

    // ---- 4: third match on the expiry edge; then a match on the edge
    //         that leaves HOLDOFF
    t0 = cyc;
    expect_at(t0 + 15, S_WIN,   2, "t4.win_c15");
    expect_at(t0 + 15, S_PULSE, 0, "t4.pulse_c15");
    expect_at(t0 + 16, S_PULSE, 1, "t4.pulse_c16");
    expect_at(t0 + 16, S_ALARM, 1, "t4.alarm_c16");
    expect_at(t0 + 17, S_PULSE, 0, "t4.pulse_c17");
    expect_at(t0 + 20, S_BUSY,  1, "t4.busy_c20");
    expect_at(t0 + 20, S_ALARM, 1, "t4.alarm_c20");
    expect_at(t0 + 21, S_BUSY,  0, "t4.busy_c21");
    expect_at(t0 + 21, S_WIN,   0, "t4.win_c21");
    expect_at(t0 + 21, S_TOTAL, 4, "t4.total_c21");
    expect_at(t0 + 21, S_ALARM, STICKY, "t4.alarm_c21");
    expect_at(t0 + 22, S_BUSY,  0, "t4.busy_c22");
    p = '0;
    p[0]  = 1'b1;
    p[1]  = 1'b1;
    p[15] = 1'b1;
    p[20] = 1'b1;
    run_pat(p, 24);
    do_clr("t4.clr");

    // ---- 5: 300 back-to-back matches saturate total_cnt; clr with match
    t0 = cyc;
    expect_at(t0 + 100, S_TOTAL, 100, "t5.total_c100");
    expect_at(t0 + 255, S_TOTAL, 255, "t5.total_c255");
    expect_at(t0 + 256, S_TOTAL, 255, "t5.total_c256");
    expect_at(t0 + 300, S_TOTAL, 255, "t5.total_c300");
    match_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
    end
    match_in = 1'b0;
    do_clr("t5.clr");

    // ---- 6: alarm followed by idle cycles, then en=0
    t0 = cyc;
    expect_at(t0 + 3,  S_PULSE, 1, "t6.pulse_c3");
    expect_at(t0 + 3,  S_ALARM, 1, "t6.alarm_c3");
    expect_at(t0 + 7,  S_ALARM, 1, "t6.alarm_c7");
    expect_at(t0 + 8,  S_ALARM, STICKY, "t6.alarm_c8");
    expect_at(t0 + 8,  S_BUSY,  0, "t6.busy_c8");
    expect_at(t0 + 27, S_ALARM, STICKY, "t6.alarm_c27");
    expect_at(t0 + 27, S_TOTAL, 3, "t6.total_c27");
    p = '0;
    p[0] = 1'b1;
    p[1] = 1'b1;
    p[2] = 1'b1;
    run_pat(p, 28);
    en = 1'b0;
    expect_at(cyc + 1, S_ALARM, STICKY, "t6.alarm_en0");
    expect_at(cyc + 1, S_BUSY,  0, "t6.busy_en0");
    step();
    en = 1'b1;
    do_clr("t6.clr");

    // ---- 7: en=0 in the middle of a window drops it; total_cnt holds
    t0 = cyc;
    expect_at(t0 + 1, S_WIN,   1, "t7.win_c1");
    expect_at(t0 + 2, S_WIN,   0, "t7.win_c2");
    expect_at(t0 + 2, S_BUSY,  0, "t7.busy_c2");
    expect_at(t0 + 2, S_TOTAL, 1, "t7.total_c2");
    expect_at(t0 + 3, S_BUSY,  0, "t7.busy_c3");
    match_in = 1'b1;
    step();
    en = 1'b0;
    step();
    en = 1'b1;
    match_in = 1'b0;
    step();
    step();

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
